// File: rtl/fsk_tx_scheduler.sv
// rtl/fsk_tx_scheduler.sv - round-robin FSK transmit sequencer with bit strobe
module fsk_tx_scheduler #(
  parameter int BIT_CYCLES = 16,
  parameter int GAP_BITS   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [13:0] code0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [13:0] code1,
  output logic        gnt1,
  output logic        tx_bit,
  output logic        tx_en,
  output logic        bit_clk,
  output logic        frame_start,
  output logic        busy,
  output logic        cur_ch
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(BIT_CYCLES / 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t        r_state;
  logic [13:0]   r_shift;
  logic [3:0]    r_bit_idx;
  logic [CW-1:0] r_cyc_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic          r_last_ch;
  logic          r_cur_ch;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_frame_start;

  state_t        w_state_nxt;
  logic [13:0]   w_shift_nxt;
  logic [3:0]    w_bit_idx_nxt;
  logic [CW-1:0] w_cyc_cnt_nxt;
  logic [GW-1:0] w_gap_cnt_nxt;
  logic          w_last_ch_nxt;
  logic          w_cur_ch_nxt;
  logic          w_gnt0_nxt;
  logic          w_gnt1_nxt;
  logic          w_frame_start_nxt;
  logic          w_sel;
  logic          w_cyc_wrap;

  // on a tie the channel that did not win last time gets the link
  assign w_sel      = (req0 & req1) ? ~r_last_ch : req1;
  assign w_cyc_wrap = (r_cyc_cnt == CYC_LAST);

  // next-state and next-register values for the IDLE/SEND/GAP sequencer
  always_comb begin
    w_state_nxt       = r_state;
    w_shift_nxt       = r_shift;
    w_bit_idx_nxt     = r_bit_idx;
    w_cyc_cnt_nxt     = r_cyc_cnt;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_last_ch_nxt     = r_last_ch;
    w_cur_ch_nxt      = r_cur_ch;
    w_gnt0_nxt        = 1'b0;
    w_gnt1_nxt        = 1'b0;
    w_frame_start_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 | req1) begin
          w_state_nxt       = S_SEND;
          w_shift_nxt       = w_sel ? code1 : code0;
          w_bit_idx_nxt     = 4'd13;
          w_cyc_cnt_nxt     = '0;
          w_last_ch_nxt     = w_sel;
          w_cur_ch_nxt      = w_sel;
          w_gnt0_nxt        = ~w_sel;
          w_gnt1_nxt        = w_sel;
          w_frame_start_nxt = 1'b1;
        end
      end
      S_SEND: begin
        w_cyc_cnt_nxt = w_cyc_wrap ? '0 : r_cyc_cnt + CW'(1);
        if (w_cyc_wrap) begin
          w_shift_nxt = {r_shift[12:0], 1'b0};
          if (r_bit_idx == 4'd0) begin
            w_gap_cnt_nxt = '0;
            w_state_nxt   = (GAP_BITS > 0) ? S_GAP : S_IDLE;
          end else begin
            w_bit_idx_nxt = r_bit_idx - 4'd1;
          end
        end
      end
      S_GAP: begin
        w_cyc_cnt_nxt = w_cyc_wrap ? '0 : r_cyc_cnt + CW'(1);
        if (w_cyc_wrap) begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + GW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state and datapath registers; reset drops the frame at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_bit_idx     <= '0;
      r_cyc_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_last_ch     <= 1'b1;
      r_cur_ch      <= 1'b0;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_bit_idx     <= w_bit_idx_nxt;
      r_cyc_cnt     <= w_cyc_cnt_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_last_ch     <= w_last_ch_nxt;
      r_cur_ch      <= w_cur_ch_nxt;
      r_gnt0        <= w_gnt0_nxt;
      r_gnt1        <= w_gnt1_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign tx_en       = (r_state == S_SEND);
  assign tx_bit      = tx_en & r_shift[13];
  assign bit_clk     = tx_en & (r_cyc_cnt < CYC_HALF);
  assign busy        = (r_state != S_IDLE);
  assign cur_ch      = r_cur_ch;
  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign frame_start = r_frame_start;

endmodule
